// File: rtl/mem_arbiter.sv
// Arbitrates the I-fetch and D-LSU ports onto one fixed-latency memory port.
// Define MEM_ARB_ROUND_ROBIN_EN to alternate grants under contention.
module mem_arbiter #(
  parameter int MEM_LATENCY = 4,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ready,
  output logic [31:0]       i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_ready,
  output logic [31:0]       d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_re,
  output logic              mem_we,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_e;

  localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 1);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              gnt_d_q, gnt_d_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       i_rdata_q, i_rdata_d;
  logic [31:0]       d_rdata_q, d_rdata_d;
  logic              pick_d;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_d_q, last_d_d;

  // Under contention the port that lost last time wins.
  assign pick_d = d_req & (~i_req | ~last_d_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      last_d_q <= 1'b0;
    end else begin
      last_d_q <= last_d_d;
    end
  end

  always_comb begin
    last_d_d = last_d_q;
    if (state_q == IDLE && (d_req || i_req)) begin
      last_d_d = pick_d;
    end
  end
`else
  assign pick_d = d_req;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      gnt_d_q   <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      gnt_d_q   <= gnt_d_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    gnt_d_d   = gnt_d_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (d_req || i_req) begin
          gnt_d_d = pick_d;
          we_d    = pick_d & d_we;
          addr_d  = pick_d ? d_addr : i_addr;
          wdata_d = pick_d ? d_wdata : '0;
          cnt_d   = CNT_INIT;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          if (we_q) begin
            d_rdata_d = '0;
          end else if (gnt_d_q) begin
            d_rdata_d = mem_rdata;
          end else begin
            i_rdata_d = mem_rdata;
          end
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  logic busy, resp;
  assign busy = (state_q == BUSY);
  assign resp = (state_q == RESP);

  assign mem_re    = busy & ~we_q;
  assign mem_we    = busy & we_q & (cnt_q == '0);
  assign mem_addr  = busy ? addr_q : '0;
  assign mem_wdata = busy ? wdata_q : '0;
  assign i_ready   = resp & ~gnt_d_q;
  assign d_ready   = resp & gnt_d_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: latency-4 instance plus a latency-1 instance.
// Expected values are hand-derived from the arbiter's timing rules.
module tb_mem_arbiter;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic        i_ready, d_ready, mem_re, mem_we;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;

  logic        i_req1, i_ready1, d_ready1, mem_re1, mem_we1;
  logic [31:0] i_rdata1, d_rdata1, mem_addr1, mem_wdata1, mem_rdata1;

  always #5 clk = ~clk;

  mem_arbiter #(.MEM_LATENCY(LAT), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr),
    .i_ready(i_ready), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_ready(d_ready), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_re(mem_re), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  mem_arbiter #(.MEM_LATENCY(1), .ADDR_W(32)) dut1 (
    .clk(clk), .reset(reset),
    .i_req(i_req1), .i_addr(32'h20),
    .i_ready(i_ready1), .i_rdata(i_rdata1),
    .d_req(1'b0), .d_we(1'b0), .d_addr(32'h0),
    .d_wdata(32'h0), .d_ready(d_ready1), .d_rdata(d_rdata1),
    .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_re(mem_re1), .mem_we(mem_we1), .mem_rdata(mem_rdata1)
  );

  // Memory model: fixed read-only words plus a write-back array.
  logic [31:0] wmem [0:63];
  always @(posedge clk) begin
    if (mem_we) wmem[mem_addr[7:2]] <= mem_wdata;
  end

  always_comb begin
    case (mem_addr)
      32'h10:  mem_rdata = 32'h0050_0093;
      32'h80:  mem_rdata = 32'h1234_5678;
      32'h84:  mem_rdata = 32'hCAFE_F00D;
      default: mem_rdata = wmem[mem_addr[7:2]];
    endcase
  end

  assign mem_rdata1 = mem_re1 ? 32'h0000_0013 : 32'h0;

  int nchk = 0;
  int nerr = 0;
  int cyc  = 0;
  int re_cnt, we_cnt, ir_cnt, dr_cnt;
  logic [31:0] we_addr, we_data, re_addr;
  int p1_times [$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mem_re) begin
      re_cnt  <= re_cnt + 1;
      re_addr <= mem_addr;
    end
    if (mem_we) begin
      we_cnt  <= we_cnt + 1;
      we_addr <= mem_addr;
      we_data <= mem_wdata;
    end
    if (i_ready) ir_cnt <= ir_cnt + 1;
    if (d_ready) dr_cnt <= dr_cnt + 1;
    if (i_ready1) p1_times.push_back(cyc);
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    @(posedge clk);
    re_cnt = 0; we_cnt = 0; ir_cnt = 0; dr_cnt = 0;
    re_addr = '0; we_addr = '0; we_data = '0;
    #1;
  endtask

  // Edges counted from the grant edge until the selected ready is seen.
  task automatic wait_rdy(input bit dport, output int n);
    n = 0;
    while (!(dport ? d_ready : i_ready) && n < 40) begin
      tick();
      n++;
    end
    if (n >= 40) chk("ready_timeout", 32'(n), 32'(0));
  endtask

  int n;
  logic first_d, exp_first_d;

  initial begin
    reset = 1'b1;
    i_req = 0; d_req = 0; d_we = 0;
    i_addr = 0; d_addr = 0; d_wdata = 0;
    i_req1 = 0;
    re_cnt = 0; we_cnt = 0; ir_cnt = 0; dr_cnt = 0;
    tick(); tick();
    chk("rst_outs", {27'd0, i_ready, d_ready, mem_re, mem_we, 1'b0}, 32'd0);
    chk("rst_addr", mem_addr | mem_wdata, 32'd0);
    chk("rst_rdata", i_rdata | d_rdata, 32'd0);
    reset = 1'b0;
    tick();
    chk("idle_stay", {30'd0, mem_re, i_ready}, 32'd0);

    // I read at 0x10: grant edge, then LAT busy cycles, then RESP.
    clr();
    i_req = 1; i_addr = 32'h10;
    tick();
    wait_rdy(1'b0, n);
    i_req = 0;
    chk("i_lat", 32'(n), 32'(LAT));
    chk("i_rdata", i_rdata, 32'h0050_0093);
    chk("i_d_ready_low", {31'd0, d_ready}, 32'd0);
    tick(); tick();
    chk("i_re_cycles", 32'(re_cnt), 32'(LAT));
    chk("i_re_addr", re_addr, 32'h10);
    chk("i_ready_once", 32'(ir_cnt), 32'd1);
    chk("i_no_we", 32'(we_cnt), 32'd0);

    // D write 0x40.
    clr();
    d_req = 1; d_we = 1; d_addr = 32'h40; d_wdata = 32'hDEAD_BEEF;
    tick();
    wait_rdy(1'b1, n);
    d_req = 0; d_we = 0;
    chk("w_lat", 32'(n), 32'(LAT));
    chk("w_rdata0", d_rdata, 32'h0);
    tick(); tick();
    chk("w_we_once", 32'(we_cnt), 32'd1);
    chk("w_we_addr", we_addr, 32'h40);
    chk("w_we_data", we_data, 32'hDEAD_BEEF);
    chk("w_no_re", 32'(re_cnt), 32'd0);
    chk("w_mem", wmem[16], 32'hDEAD_BEEF);
    chk("w_ready_once", 32'(dr_cnt), 32'd1);

    // Contention right after a D grant.
`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_first_d = 1'b0;
`else
    exp_first_d = 1'b1;
`endif
    clr();
    i_req = 1; i_addr = 32'h10;
    d_req = 1; d_addr = 32'h84;
    tick();
    n = 0;
    while (!(i_ready || d_ready) && n < 40) begin
      tick();
      n++;
    end
    first_d = d_ready;
    chk("arb_first", {31'd0, first_d}, {31'd0, exp_first_d});
    chk("arb_lat", 32'(n), 32'(LAT));
    if (first_d) d_req = 0;
    else i_req = 0;
    tick();
    wait_rdy(~first_d, n);
    i_req = 0; d_req = 0;
    chk("arb_gap", 32'(n + 1), 32'(LAT + 2));
    chk("arb_i_rdata", i_rdata, 32'h0050_0093);
    chk("arb_d_rdata", d_rdata, 32'hCAFE_F00D);
    tick();

    // D read at 0x80 with req dropped after the grant.
    clr();
    d_req = 1; d_addr = 32'h80;
    tick();
    d_req = 0;
    wait_rdy(1'b1, n);
    chk("drop_lat", 32'(n), 32'(LAT));
    chk("drop_rdata", d_rdata, 32'h1234_5678);
    tick();

    // Reset in the 2nd busy cycle of a write.
    clr();
    d_req = 1; d_we = 1; d_addr = 32'h44; d_wdata = 32'h1111_2222;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    d_req = 0; d_we = 0;
    chk("abort_outs", {27'd0, i_ready, d_ready, mem_re, mem_we, 1'b0}, 32'd0);
    chk("abort_addr", mem_addr | mem_wdata, 32'd0);
    chk("abort_irdata", i_rdata, 32'h0);
    for (int k = 0; k < LAT + 3; k++) tick();
    chk("abort_no_we", 32'(we_cnt), 32'd0);
    chk("abort_no_rdy", 32'(dr_cnt), 32'd0);
    i_req = 1; i_addr = 32'h10;
    tick();
    wait_rdy(1'b0, n);
    i_req = 0;
    chk("post_lat", 32'(n), 32'(LAT));
    chk("post_rdata", i_rdata, 32'h0050_0093);

    // Latency-1 instance, request held high.
    p1_times.delete();
    i_req1 = 1;
    for (int k = 0; k < 14; k++) tick();
    i_req1 = 0;
    chk("l1_count_ge4", 32'(p1_times.size() >= 4), 32'd1);
    for (int k = 1; k < p1_times.size(); k++) begin
      chk("l1_period", 32'(p1_times[k] - p1_times[k-1]), 32'd3);
    end
    chk("l1_rdata", i_rdata1, 32'h0000_0013);
    chk("l1_no_d", {31'd0, d_ready1 | mem_we1}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
